// File: rtl/blob_pipeline.sv
// Streaming connected-component (blob) counter.
// One binary pixel per accepted cycle, raster order, IMG_ROW x IMG_COL frame.
// Stage 1 registers the pixel and reads the previous-row labels from the
// line buffer. Stage 2 translates the labels through the flat equivalence table,
// picks the pixel label, and updates the table, the counters and the line buffer.
// Optional feature macro: BLOB_8CONN_EN (8-connectivity; 4-connectivity otherwise).
// Assumes IMG_COL >= 3 and TABLE_ENTRY < 2**LABEL_W so the allocator cannot wrap.
// Handshake: a pixel is accepted in a cycle where i_valid & i_data_valid &
// i_proc_ccd is high. o_valid is a level that marks o_count as the result of
// the last completed frame.
module blob_pipeline #(
  parameter int IMG_ROW     = 600,
  parameter int IMG_COL     = 800,
  parameter int TABLE_ENTRY = 100,
  parameter int LABEL_W     = 7
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_valid,
  input  logic       i_seq,
  input  logic       i_data_valid,
  input  logic       i_proc_ccd,
  output logic       o_valid,
  output logic [7:0] o_count
);

  localparam int COL_W = $clog2(IMG_COL + 2);
  localparam int ROW_W = $clog2(IMG_ROW);
  localparam logic [LABEL_W-1:0] MAX_LABEL = LABEL_W'(TABLE_ENTRY - 1);

  logic accept;
  logic fire;
  logic last_col;
  logic last_row;

  logic [COL_W-1:0]   col_q;
  logic [ROW_W-1:0]   row_q;

  logic               s1_valid;
  logic               s1_pix;
  logic               s1_last;
  logic [COL_W-1:0]   s1_col;
  logic [LABEL_W-1:0] u_raw;
`ifdef BLOB_8CONN_EN
  logic [LABEL_W-1:0] ul_raw;
  logic [LABEL_W-1:0] ur_raw;
  logic [LABEL_W-1:0] ul_rep;
  logic [LABEL_W-1:0] ur_rep;
`endif

  logic [LABEL_W-1:0] line_buf [IMG_COL+2];
  logic [LABEL_W-1:0] table_q  [TABLE_ENTRY];

  logic [LABEL_W-1:0] left_q;
  logic [LABEL_W-1:0] next_label;
  logic [LABEL_W-1:0] count_q;
  logic [LABEL_W-1:0] final_q;
  logic               eof_pend;

  logic [LABEL_W-1:0] l_raw;
  logic [LABEL_W-1:0] l_rep;
  logic [LABEL_W-1:0] u_rep;
  logic [LABEL_W-1:0] cand_p;
  logic [LABEL_W-1:0] cand_q;
  logic [LABEL_W-1:0] lo;
  logic [LABEL_W-1:0] hi;
  logic [LABEL_W-1:0] new_label;
  logic [LABEL_W-1:0] count_next;
  logic               do_alloc;
  logic               do_merge;

  assign accept   = i_valid & i_data_valid & i_proc_ccd;
  assign last_col = (col_q == COL_W'(IMG_COL - 1));
  assign last_row = (row_q == ROW_W'(IMG_ROW - 1));
  // Stage 2 advances together with the next accepted pixel, so stalls keep
  // both stages frozen. The final pixel of a frame is flushed on its own.
  assign fire     = s1_valid & i_proc_ccd & (accept | s1_last);

  // Row/column position of the next pixel to accept.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else if (!i_proc_ccd) begin
      col_q <= '0;
      row_q <= '0;
    end else if (accept) begin
      if (last_col) begin
        col_q <= '0;
        row_q <= last_row ? '0 : row_q + ROW_W'(1);
      end else begin
        col_q <= col_q + COL_W'(1);
      end
    end
  end

  // Stage 1: register the pixel and read the previous-row labels. Row 0 and the
  // frame borders read as background, so stale contents never leak in.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid <= 1'b0;
      s1_pix   <= 1'b0;
      s1_last  <= 1'b0;
      s1_col   <= '0;
      u_raw    <= '0;
`ifdef BLOB_8CONN_EN
      ul_raw   <= '0;
      ur_raw   <= '0;
`endif
    end else if (!i_proc_ccd) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_pix   <= i_seq;
      s1_last  <= last_col & last_row;
      s1_col   <= col_q;
      u_raw    <= (row_q == '0) ? '0 : line_buf[col_q + COL_W'(1)];
`ifdef BLOB_8CONN_EN
      ul_raw   <= (row_q == '0 || col_q == '0) ? '0 : line_buf[col_q];
      ur_raw   <= (row_q == '0 || last_col) ? '0 : line_buf[col_q + COL_W'(2)];
`endif
    end else if (fire) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
    end
  end

  // Stage 2 label decision. Neighbours are reduced to two candidates, and
  // the result is either a new label, an inherited label or one merge.
  always_comb begin
    l_raw      = (s1_col == '0) ? '0 : left_q;
    l_rep      = table_q[l_raw];
    u_rep      = table_q[u_raw];
`ifdef BLOB_8CONN_EN
    ul_rep     = table_q[ul_raw];
    ur_rep     = table_q[ur_raw];
    cand_p     = (u_rep != '0) ? u_rep : ur_rep;
    cand_q     = (u_rep != '0) ? l_rep : ((l_rep != '0) ? l_rep : ul_rep);
`else
    cand_p     = u_rep;
    cand_q     = l_rep;
`endif
    lo         = (cand_p < cand_q) ? cand_p : cand_q;
    hi         = (cand_p < cand_q) ? cand_q : cand_p;
    new_label  = '0;
    do_alloc   = 1'b0;
    do_merge   = 1'b0;
    if (s1_pix) begin
      if (cand_p == '0 && cand_q == '0) begin
        // Once the allocator is exhausted, new components count as background.
        if (next_label <= MAX_LABEL) begin
          new_label = next_label;
          do_alloc  = 1'b1;
        end
      end else if (cand_p == '0) begin
        new_label = cand_q;
      end else if (cand_q == '0 || cand_p == cand_q) begin
        new_label = cand_p;
      end else begin
        new_label = lo;
        do_merge  = 1'b1;
      end
    end
    count_next = count_q + LABEL_W'(do_alloc) - LABEL_W'(do_merge);
  end

  // Equivalence table: the parallel rewrite of every hi entry to lo keeps it flat.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < TABLE_ENTRY; i++) table_q[i] <= '0;
    end else if (!i_proc_ccd || (fire && s1_last)) begin
      for (int i = 0; i < TABLE_ENTRY; i++) table_q[i] <= '0;
    end else if (fire) begin
      for (int i = 0; i < TABLE_ENTRY; i++) begin
        if (do_merge && table_q[i] == hi) table_q[i] <= lo;
        if (do_alloc && LABEL_W'(i) == next_label) table_q[i] <= next_label;
      end
    end
  end

  // Line buffer: synchronous RAM. Each pixel writes its raw label at col+1.
  always_ff @(posedge i_clk) begin
    if (fire) line_buf[s1_col + COL_W'(1)] <= new_label;
  end

  // Stage 2 state: left forwarding, allocator, running count and frame result.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      left_q     <= '0;
      next_label <= LABEL_W'(1);
      count_q    <= '0;
      final_q    <= '0;
      eof_pend   <= 1'b0;
    end else if (!i_proc_ccd) begin
      left_q     <= '0;
      next_label <= LABEL_W'(1);
      count_q    <= '0;
      eof_pend   <= 1'b0;
    end else begin
      eof_pend <= fire & s1_last;
      if (fire) begin
        left_q <= new_label;
        if (s1_last) begin
          final_q    <= count_next;
          count_q    <= '0;
          next_label <= LABEL_W'(1);
        end else begin
          count_q    <= count_next;
          if (do_alloc) next_label <= next_label + LABEL_W'(1);
        end
      end
    end
  end

  // Result outputs: publish one cycle after the final pixel leaves stage 2.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_count <= '0;
    end else if (!i_proc_ccd) begin
      o_valid <= 1'b0;
    end else if (eof_pend) begin
      o_valid <= 1'b1;
      o_count <= 8'(final_q);
    end else if (accept && col_q == '0 && row_q == '0) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_blob_pipeline.sv
// Bench for blob_pipeline on a reduced 24x32 frame. The reference model
// scans each frame in raster order. It uses a union-find over labels and a
// budget of 99 labels.
module tb_blob_pipeline;

  localparam int R = 24;
  localparam int C = 32;
  localparam int MAX_LABELS = 99;

  logic       clk;
  logic       i_rst_n;
  logic       i_valid;
  logic       i_seq;
  logic       i_data_valid;
  logic       i_proc_ccd;
  logic       o_valid;
  logic [7:0] o_count;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  int last_count = 0;

  bit img   [R][C];
  int lab_m [R][C];
  int par   [MAX_LABELS+1];

  blob_pipeline #(.IMG_ROW(R), .IMG_COL(C), .TABLE_ENTRY(100), .LABEL_W(7)) dut (
    .i_clk(clk),
    .i_rst_n(i_rst_n),
    .i_valid(i_valid),
    .i_seq(i_seq),
    .i_data_valid(i_data_valid),
    .i_proc_ccd(i_proc_ccd),
    .o_valid(o_valid),
    .o_count(o_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int find_root(input int x);
    int y;
    y = x;
    while (par[y] != y) y = par[y];
    return y;
  endfunction

  function automatic int model_count();
    int nxt;
    int cnt;
    int nb[4];
    int m;
    int rt;
    nxt = 1;
    cnt = 0;
    for (int k = 0; k <= MAX_LABELS; k++) par[k] = k;
    for (int r = 0; r < R; r++) begin
      for (int c = 0; c < C; c++) begin
        lab_m[r][c] = 0;
        if (img[r][c]) begin
          nb = '{0, 0, 0, 0};
          if (c > 0) nb[0] = lab_m[r][c-1];
          if (r > 0) nb[1] = lab_m[r-1][c];
`ifdef BLOB_8CONN_EN
          if (r > 0 && c > 0) nb[2] = lab_m[r-1][c-1];
          if (r > 0 && c < C-1) nb[3] = lab_m[r-1][c+1];
`endif
          m = 0;
          for (int k = 0; k < 4; k++) begin
            if (nb[k] != 0) begin
              rt = find_root(nb[k]);
              if (m == 0 || rt < m) m = rt;
            end
          end
          if (m == 0) begin
            if (nxt <= MAX_LABELS) begin
              lab_m[r][c] = nxt;
              par[nxt] = nxt;
              nxt++;
              cnt++;
            end
          end else begin
            for (int k = 0; k < 4; k++) begin
              if (nb[k] != 0) begin
                rt = find_root(nb[k]);
                if (rt != m) begin
                  par[rt] = m;
                  cnt--;
                end
              end
            end
            lab_m[r][c] = m;
          end
        end
      end
    end
    return cnt;
  endfunction

  // ---------------- image helpers ----------------
  task automatic clear_img();
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) img[r][c] = 1'b0;
  endtask

  task automatic fill_rect(input int r0, input int r1, input int c0, input int c1);
    for (int r = r0; r <= r1; r++)
      for (int c = c0; c <= c1; c++) img[r][c] = 1'b1;
  endtask

  task automatic random_img(input int dens);
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) img[r][c] = ($urandom_range(0, 99) < dens);
  endtask

  // ---------------- driver ----------------
  task automatic send_pixels(input int n, input int blank_pct);
    int r;
    int c;
    for (int idx = 0; idx < n; idx++) begin
      r = idx / C;
      c = idx % C;
      while ($urandom_range(0, 99) < blank_pct) begin
        if ($urandom_range(0, 1) == 1) begin
          i_valid = 1'b1;
          i_data_valid = 1'b0;
        end else begin
          i_valid = 1'b0;
          i_data_valid = 1'b1;
        end
        i_seq = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      i_valid = 1'b1;
      i_data_valid = 1'b1;
      i_seq = img[r][c];
      @(negedge clk);
      if (idx == 0) check_val("first_pixel_clears_valid", o_valid, 0);
    end
    i_data_valid = 1'b0;
    i_seq = 1'b0;
  endtask

  // Sends one full frame and checks the result timing and value.
  task automatic run_frame(input string tag, input int blank_pct, input int spec_exp);
    logic [7:0] exp;
    int idle;
    exp_q.push_back(8'(model_count()));
    send_pixels(R * C, blank_pct);
    @(negedge clk);
    check_val({tag, "_valid_early"}, o_valid, 0);
    @(negedge clk);
    exp = exp_q.pop_front();
    check_val({tag, "_valid_rise"}, o_valid, 1);
    check_val({tag, "_count"}, o_count, exp);
    if (spec_exp >= 0) check_val({tag, "_count_plan"}, o_count, spec_exp);
    last_count = exp;
    idle = $urandom_range(1, 4);
    repeat (idle) @(negedge clk);
    check_val({tag, "_valid_hold"}, o_valid, 1);
    check_val({tag, "_count_hold"}, o_count, exp);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int idx;
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_seq = 1'b0;
    i_data_valid = 1'b0;
    i_proc_ccd = 1'b1;
    repeat (3) @(negedge clk);
    check_val("reset_valid", o_valid, 0);
    check_val("reset_count", o_count, 0);
    i_rst_n = 1'b1;
    @(negedge clk);

    clear_img();
    run_frame("all_zero", 20, 0);

    clear_img();
    img[10][10] = 1'b1;
    run_frame("single", 20, 1);

    clear_img();
    fill_rect(2, 6, 2, 6);
    fill_rect(12, 16, 15, 19);
    run_frame("squares", 30, 2);

    clear_img();
    fill_rect(2, 10, 3, 3);
    fill_rect(2, 10, 8, 8);
    fill_rect(10, 10, 3, 8);
    run_frame("u_shape", 20, 1);

    clear_img();
    img[5][5] = 1'b1;
    img[6][6] = 1'b1;
`ifdef BLOB_8CONN_EN
    run_frame("diagonal", 20, 1);
`else
    run_frame("diagonal", 20, 2);
`endif

    // processing disable: drops o_valid, keeps o_count, aborts a partial frame
    i_proc_ccd = 1'b0;
    @(negedge clk);
    check_val("proc_low_valid", o_valid, 0);
    check_val("proc_low_count_kept", o_count, last_count);
    i_proc_ccd = 1'b1;
    random_img(40);
    send_pixels(300, 20);
    i_proc_ccd = 1'b0;
    @(negedge clk);
    i_proc_ccd = 1'b1;
    random_img(35);
    run_frame("after_abort", 20, -1);

    clear_img();
    idx = 0;
    for (int r = 0; r < R; r += 2)
      for (int c = 0; c < C; c += 2)
        if (idx < 150) begin
          img[r][c] = 1'b1;
          idx++;
        end
    run_frame("saturate", 10, 99);

    clear_img();
    run_frame("zero_after_sat", 10, 0);

    for (int k = 0; k < 6; k++) begin
      random_img($urandom_range(10, 60));
      run_frame("random", 30, -1);
    end

    // asynchronous reset in the middle of a frame
    random_img(30);
    send_pixels(200, 10);
    i_rst_n = 1'b0;
    #1;
    check_val("midframe_reset_valid", o_valid, 0);
    check_val("midframe_reset_count", o_count, 0);
    @(negedge clk);
    i_rst_n = 1'b1;
    @(negedge clk);
    random_img(30);
    run_frame("after_reset", 20, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
